// File: rtl/pll_drp_sequencer.sv
// Reset/DRP sequencer for one PLLE2_ADV: power-on lock, CLKOUT0/1 divide reconfiguration, re-lock.
// Optional PLL_DRP_READBACK_EN: re-read and compare each DRP write before re-locking.
//
// state        | meaning
// RST_HOLD     | pll_rst high for RST_CYCLES cycles
// WAIT_LOCK    | pll_rst low, waiting for synchronised lock (timeout -> retry / error)
// IDLE         | locked or failed, cfg_ready high
// RD1 / RD1_W  | issue / await ClkReg1 read
// WR1 / WR1_W  | issue / await ClkReg1 write
// RD2 / RD2_W  | issue / await ClkReg2 read
// WR2 / WR2_W  | issue / await ClkReg2 write
// VFY / VFY_W  | issue / await readback of the last write (PLL_DRP_READBACK_EN only)
module pll_drp_sequencer #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int MAX_RETRY    = 3,
   parameter int DRDY_TIMEOUT = 255
) (
   input  logic        clk_in1,
   input  logic        reset_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        cfg_sel,
   input  logic [6:0]  cfg_divide,
   output logic        pll_rst,
   input  logic        pll_locked,
   output logic [6:0]  daddr,
   output logic [15:0] di,
   input  logic [15:0] do_in,
   output logic        den,
   output logic        dwe,
   input  logic        drdy,
   output logic        busy,
   output logic        locked,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam int T_A  = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int TMAX = (T_A > RST_CYCLES) ? T_A : RST_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [TW-1:0] T_RST  = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCK = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] T_DRDY = TW'(DRDY_TIMEOUT);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

   typedef enum logic [3:0] {
      ST_RST_HOLD, ST_WAIT_LOCK, ST_IDLE,
      ST_RD1, ST_RD1_W, ST_WR1, ST_WR1_W,
      ST_RD2, ST_RD2_W, ST_WR2, ST_WR2_W
`ifdef PLL_DRP_READBACK_EN
      , ST_VFY, ST_VFY_W
`endif
   } state_t;

   state_t          state_q;
   logic [TW-1:0]   timer_q;
   logic [RW-1:0]   retry_q;
   logic            sync1_q, sync2_q, lock_prev_q;
   logic            pll_rst_q, den_q, dwe_q, done_q, err_q;
   logic [6:0]      daddr_q;
   logic [15:0]     di_q, rd_q;
   logic [1:0]      err_code_q;
   logic            sel_q;
   logic [6:0]      div_q;
`ifdef PLL_DRP_READBACK_EN
   logic            second_q;
`endif

   logic [7:0]  div_full;
   logic [5:0]  hi6, lo6;
   logic [6:0]  addr1, addr2;
   logic [15:0] wr1_data, wr2_data;
   logic        lock_fall;
   logic        unused_rd;

   // Divide split into high/low counts modulo 64, so 64 encodes as 0.
   assign div_full  = (div_q == 7'd0) ? 8'd128 : {1'b0, div_q};
   assign hi6       = div_full[6:1];
   assign lo6       = div_full[5:0] - hi6;
   assign addr1     = sel_q ? 7'h0A : 7'h08;
   assign addr2     = sel_q ? 7'h0B : 7'h09;
   assign wr1_data  = {rd_q[15:12], hi6, lo6};
   assign wr2_data  = {rd_q[15:8], div_full[0], (div_full == 8'd1), rd_q[5:0]};
   assign lock_fall = lock_prev_q & ~sync2_q;
   assign unused_rd = ^rd_q[7:6];

   always_ff @(posedge clk_in1) begin
      if (!reset_n) begin
         state_q     <= ST_RST_HOLD;
         timer_q     <= T_RST;
         retry_q     <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         lock_prev_q <= 1'b0;
         pll_rst_q   <= 1'b1;
         den_q       <= 1'b0;
         dwe_q       <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         daddr_q     <= '0;
         di_q        <= '0;
         rd_q        <= '0;
         err_code_q  <= 2'b00;
         sel_q       <= 1'b0;
         div_q       <= '0;
`ifdef PLL_DRP_READBACK_EN
         second_q    <= 1'b0;
`endif
      end else begin
         sync1_q     <= pll_locked;
         sync2_q     <= sync1_q;
         lock_prev_q <= sync2_q;
         den_q       <= 1'b0;
         dwe_q       <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            ST_RST_HOLD: begin
               if (timer_q == '0) begin
                  pll_rst_q <= 1'b0;
                  timer_q   <= T_LOCK;
                  state_q   <= ST_WAIT_LOCK;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (sync2_q) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (timer_q == '0) begin
                  if (retry_q == R_MAX) begin
                     err_q      <= 1'b1;
                     err_code_q <= 2'b10;
                     state_q    <= ST_IDLE;
                  end else begin
                     retry_q   <= retry_q + RW'(1);
                     pll_rst_q <= 1'b1;
                     timer_q   <= T_RST;
                     state_q   <= ST_RST_HOLD;
                  end
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            ST_IDLE: begin
               // A request wins over a simultaneous lock loss; both end in a reset pulse.
               if (cfg_valid) begin
                  sel_q      <= cfg_sel;
                  div_q      <= cfg_divide;
                  err_code_q <= 2'b00;
                  retry_q    <= '0;
                  pll_rst_q  <= 1'b1;
                  state_q    <= ST_RD1;
               end else if (lock_fall) begin
                  retry_q   <= '0;
                  pll_rst_q <= 1'b1;
                  timer_q   <= T_RST;
                  state_q   <= ST_RST_HOLD;
               end
            end
            ST_RD1, ST_RD2: begin
               den_q   <= 1'b1;
               daddr_q <= (state_q == ST_RD1) ? addr1 : addr2;
               timer_q <= T_DRDY;
               state_q <= (state_q == ST_RD1) ? ST_RD1_W : ST_RD2_W;
            end
            ST_WR1, ST_WR2: begin
               den_q   <= 1'b1;
               dwe_q   <= 1'b1;
               daddr_q <= (state_q == ST_WR1) ? addr1 : addr2;
               di_q    <= (state_q == ST_WR1) ? wr1_data : wr2_data;
               timer_q <= T_DRDY;
               state_q <= (state_q == ST_WR1) ? ST_WR1_W : ST_WR2_W;
            end
`ifdef PLL_DRP_READBACK_EN
            ST_VFY: begin
               den_q   <= 1'b1;
               timer_q <= T_DRDY;
               state_q <= ST_VFY_W;
            end
`endif
            default: begin
               if (drdy) begin
                  case (state_q)
                     ST_RD1_W: begin
                        rd_q    <= do_in;
                        state_q <= ST_WR1;
                     end
                     ST_RD2_W: begin
                        rd_q    <= do_in;
                        state_q <= ST_WR2;
                     end
`ifdef PLL_DRP_READBACK_EN
                     ST_WR1_W: begin
                        second_q <= 1'b0;
                        state_q  <= ST_VFY;
                     end
                     ST_WR2_W: begin
                        second_q <= 1'b1;
                        state_q  <= ST_VFY;
                     end
                     ST_VFY_W: begin
                        if (do_in != di_q) begin
                           err_q      <= 1'b1;
                           err_code_q <= 2'b11;
                           timer_q    <= T_RST;
                           state_q    <= ST_RST_HOLD;
                        end else if (second_q) begin
                           timer_q <= T_RST;
                           state_q <= ST_RST_HOLD;
                        end else begin
                           state_q <= ST_RD2;
                        end
                     end
`else
                     ST_WR1_W: state_q <= ST_RD2;
                     ST_WR2_W: begin
                        timer_q <= T_RST;
                        state_q <= ST_RST_HOLD;
                     end
`endif
                     default: begin
                        pll_rst_q <= 1'b1;
                        timer_q   <= T_RST;
                        state_q   <= ST_RST_HOLD;
                     end
                  endcase
               end else if (timer_q == '0) begin
                  // PLL is re-locked with whatever has already been written.
                  err_q      <= 1'b1;
                  err_code_q <= 2'b01;
                  pll_rst_q  <= 1'b1;
                  timer_q    <= T_RST;
                  state_q    <= ST_RST_HOLD;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
         endcase
      end
   end

   assign cfg_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign pll_rst   = pll_rst_q;
   assign locked    = sync2_q & ~pll_rst_q;
   assign daddr     = daddr_q;
   assign di        = di_q;
   assign den       = den_q;
   assign dwe       = dwe_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Directed bench for pll_drp_sequencer with behavioural PLL lock and DRP register models.
module tb_pll_drp_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_valid, cfg_ready, cfg_sel;
   logic [6:0]  cfg_divide;
   logic        pll_rst;
   logic        pll_locked = 1'b0;
   logic [6:0]  daddr;
   logic [15:0] di;
   logic [15:0] do_in = 16'h0;
   logic        den, dwe;
   logic        drdy = 1'b0;
   logic        busy, locked, done, err;
   logic [1:0]  err_code;

   int compared = 0;
   int failed   = 0;

   logic        lock_en, force_unlock, drdy_hold;
   logic        pl_req;
   logic [6:0]  pl_addr;
   logic [15:0] pl_data;
   logic [15:0] regs [0:127];
   logic [6:0]  drp_a = 7'h0;
   int          drp_lat = 0;
   int          lock_cnt = 0;

   int done_cnt = 0, err_cnt = 0, rise_cnt = 0, both_cnt = 0, den_unrst_cnt = 0;
   logic prev_rst = 1'b1;

   pll_drp_sequencer #(
      .RST_CYCLES(16), .LOCK_TIMEOUT(200), .MAX_RETRY(3), .DRDY_TIMEOUT(255)
   ) dut (
      .clk_in1(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sel(cfg_sel), .cfg_divide(cfg_divide), .pll_rst(pll_rst), .pll_locked(pll_locked),
      .daddr(daddr), .di(di), .do_in(do_in), .den(den), .dwe(dwe), .drdy(drdy),
      .busy(busy), .locked(locked), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // PLL: locks 100 cycles after RST falls when enabled.
   always @(posedge clk) begin
      if (pll_rst) begin
         lock_cnt   <= 0;
         pll_locked <= 1'b0;
      end else begin
         if (lock_cnt < 100000) lock_cnt <= lock_cnt + 1;
         if (force_unlock) pll_locked <= 1'b0;
         else if (lock_en && lock_cnt >= 99) pll_locked <= 1'b1;
      end
   end

   // DRP: drdy two cycles after den, unless withheld.
   always @(posedge clk) begin
      drdy <= 1'b0;
      if (pl_req) regs[pl_addr] <= pl_data;
      if (den && !drdy_hold) begin
         drp_lat <= 2;
         drp_a   <= daddr;
         if (dwe) regs[daddr] <= di;
      end else if (drp_lat != 0) begin
         drp_lat <= drp_lat - 1;
         if (drp_lat == 1) begin
            drdy  <= 1'b1;
            do_in <= regs[drp_a];
         end
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (done && err) both_cnt <= both_cnt + 1;
      if (den && !pll_rst) den_unrst_cnt <= den_unrst_cnt + 1;
      if (pll_rst && !prev_rst) rise_cnt <= rise_cnt + 1;
      prev_rst <= pll_rst;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pulse(input string tag, input bit want_err, input int max_cyc);
      int n = 0;
      while (((want_err ? err : done) !== 1'b1) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'((want_err ? err : done) === 1'b1), 32'd1);
   endtask

   task automatic preload(input logic [6:0] a, input logic [15:0] v);
      pl_addr = a;
      pl_data = v;
      pl_req  = 1'b1;
      @(negedge clk);
      pl_req  = 1'b0;
   endtask

   task automatic do_request(input logic s, input logic [6:0] d);
      cfg_sel    = s;
      cfg_divide = d;
      cfg_valid  = 1'b1;
      @(negedge clk);
      cfg_valid  = 1'b0;
      chk("acc_busy", 32'(busy), 32'd1);
      chk("acc_rst", 32'(pll_rst), 32'd1);
   endtask

   task automatic wait_den(input string tag);
      int n = 0;
      while (den !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(den), 32'd1);
   endtask

   initial begin
      int n, m, nl, nr, r0, d0;
      reset_n = 1'b0; cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_divide = 7'd0;
      lock_en = 1'b1; force_unlock = 1'b0; drdy_hold = 1'b0;
      pl_req = 1'b0; pl_addr = 7'h0; pl_data = 16'h0;
      repeat (3) @(negedge clk);

      // 1: reset values and power-on lock
      chk("rst_pll_rst", 32'(pll_rst), 32'd1);
      chk("rst_den", 32'(den), 32'd0);
      chk("rst_dwe", 32'(dwe), 32'd0);
      chk("rst_daddr", 32'(daddr), 32'd0);
      chk("rst_di", 32'(di), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_done_err", 32'({done, err}), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      preload(7'h08, 16'hF000);
      preload(7'h09, 16'h0000);
      preload(7'h0A, 16'hFFFF);
      preload(7'h0B, 16'hFFFF);
      reset_n = 1'b1;
      n = 0;
      while (pll_rst === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("por_rst_width", 32'(n), 32'd16);
      wait_pulse("por_done", 1'b0, 400);
      chk("por_locked", 32'(locked), 32'd1);
      chk("por_ready", 32'(cfg_ready), 32'd1);
      chk("por_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      chk("por_done_once", 32'(done_cnt), 32'd1);

      // 2: CLKOUT0 divide 5
      do_request(1'b0, 7'd5);
      wait_pulse("d5_done", 1'b0, 600);
      chk("d5_reg1", 32'(regs[8]), 32'h0000F083);
      chk("d5_reg2", 32'(regs[9]), 32'h00000080);
      chk("d5_err_code", 32'(err_code), 32'd0);
      chk("d5_locked", 32'(locked), 32'd1);
      chk("d5_den_in_rst", 32'(den_unrst_cnt), 32'd0);

      // 3: CLKOUT1 divide 128, then divide 1
      @(negedge clk);
      do_request(1'b1, 7'd0);
      wait_pulse("d128_done", 1'b0, 600);
      chk("d128_reg1", 32'(regs[10]), 32'h0000F000);
      chk("d128_reg2", 32'(regs[11]), 32'h0000FF3F);
      @(negedge clk);
      do_request(1'b1, 7'd1);
      wait_pulse("d1_done", 1'b0, 600);
      chk("d1_reg1", 32'(regs[10]), 32'h0000F001);
      chk("d1_reg2", 32'(regs[11]), 32'h0000FFFF);

      // 5: drdy withheld
      @(negedge clk);
      drdy_hold = 1'b1;
      do_request(1'b0, 7'd5);
      wait_den("to_den");
      m = 0;
      while (err !== 1'b1 && m < 400) begin
         @(negedge clk);
         m++;
      end
      chk("to_err_delay", 32'(m), 32'd256);
      chk("to_err_code", 32'(err_code), 32'd1);
      chk("to_busy", 32'(busy), 32'd1);
      drdy_hold = 1'b0;
      @(negedge clk);
      wait_pulse("to_relock_done", 1'b0, 500);
      chk("to_code_held", 32'(err_code), 32'd1);
      chk("to_reg1_kept", 32'(regs[8]), 32'h0000F083);

      // 6: lock loss in IDLE, request held high during relock
      @(negedge clk);
      force_unlock = 1'b1;
      n = 0; nl = -1; nr = -1;
      while (nr < 0 && n < 20) begin
         @(negedge clk);
         n++;
         if (nl < 0 && pll_locked === 1'b0) nl = n;
         if (pll_rst === 1'b1) nr = n;
      end
      chk("loss_rise_window", 32'(nl > 0 && nr > nl && (nr - nl) <= 3), 32'd1);
      force_unlock = 1'b0;
      cfg_sel = 1'b0; cfg_divide = 7'd3; cfg_valid = 1'b1;
      chk("loss_ready_low", 32'(cfg_ready), 32'd0);
      n = 0;
      while (cfg_ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("loss_ready_back", 32'(cfg_ready), 32'd1);
      chk("loss_accept_with_done", 32'(done), 32'd1);
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("loss_accepted", 32'(busy), 32'd1);
      wait_pulse("d3_done", 1'b0, 600);
      chk("d3_reg1", 32'(regs[8]), 32'h0000F042);
      chk("d3_reg2", 32'(regs[9]), 32'h00000080);

      // 4: PLL never locks
      @(negedge clk);
      lock_en = 1'b0;
      r0 = rise_cnt;
      d0 = done_cnt;
      do_request(1'b1, 7'd7);
      wait_pulse("nolock_err", 1'b1, 3000);
      chk("nolock_code", 32'(err_code), 32'd2);
      chk("nolock_busy", 32'(busy), 32'd0);
      chk("nolock_pll_rst", 32'(pll_rst), 32'd0);
      chk("nolock_locked", 32'(locked), 32'd0);
      repeat (50) @(negedge clk);
      chk("nolock_pulses", 32'(rise_cnt - r0), 32'd4);
      chk("nolock_no_done", 32'(done_cnt - d0), 32'd0);
      chk("nolock_ready", 32'(cfg_ready), 32'd1);

      // reset mid-sequence
      lock_en = 1'b1;
      do_request(1'b0, 7'd9);
      wait_den("abort_den");
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_pll_rst", 32'(pll_rst), 32'd1);
      chk("abort_den_dwe", 32'({den, dwe}), 32'd0);
      chk("abort_daddr_di", 32'({daddr, di}), 32'd0);
      chk("abort_err_code", 32'(err_code), 32'd0);
      chk("abort_busy", 32'(busy), 32'd1);
      reset_n = 1'b1;
      wait_pulse("abort_done", 1'b0, 500);
      chk("abort_locked", 32'(locked), 32'd1);

      chk("done_err_overlap", 32'(both_cnt), 32'd0);
      chk("den_outside_rst", 32'(den_unrst_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/pll_drp_sequencer.md
Name: pll_drp_sequencer

Overview:
Controller that owns the reset and DRP port of one PLLE2_ADV and sequences runtime reconfiguration of the CLKOUT0/CLKOUT1 divide values.
- Sequence per request: hold PLL in reset, read-modify-write the ClkReg1/ClkReg2 pair, release reset, wait for lock with timeout and bounded retry.
- Also performs power-on reset/lock sequencing, and re-lock when lock is lost.
- Sits between the clock synth wrapper (PLL plus BUFGs) and user logic that selects output frequencies.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset pulse (min 1)
LOCK_TIMEOUT, 65535, cycles to wait for pll_locked after reset release
MAX_RETRY, 3, additional reset pulses after a lock timeout before error
DRDY_TIMEOUT, 255, cycles to wait for drdy after den before error

Ports:
clk_in1  in  1  free-running sequencer clock; must not be a PLL output
reset_n  in  1  synchronous, active-low reset
cfg_valid  in  1  reconfiguration request
cfg_ready  out  1  high only in IDLE; transfer occurs when cfg_valid & cfg_ready
cfg_sel  in  1  0 = CLKOUT0, 1 = CLKOUT1
cfg_divide  in  7  divide 1..127; 0 encodes 128
pll_rst  out  1  to PLL RST, active-high
pll_locked  in  1  PLL LOCKED, asynchronous; double-flop synchronised internally
daddr  out  7  DRP address
di  out  16  DRP write data
do_in  in  16  DRP read data
den  out  1  DRP enable, one-cycle pulse
dwe  out  1  DRP write enable, valid with den
drdy  in  1  DRP ready
busy  out  1  high in every state except IDLE
locked  out  1  synchronised lock, gated low while pll_rst is high
done  out  1  one-cycle pulse: sequence finished and locked
err  out  1  one-cycle pulse: drdy timeout or lock retries exhausted
err_code  out  2  00 none, 01 drdy timeout, 10 lock fail, 11 readback mismatch; holds until next accepted request

Behaviour:
- Reset (reset_n=0 at a clk_in1 edge) drives: pll_rst=1, den=0, dwe=0, daddr=0, di=0, cfg_ready=0, busy=1, locked=0, done=0, err=0, err_code=00. FSM enters RST_HOLD.
- States: RST_HOLD → WAIT_LOCK → IDLE; IDLE → RD1 → RD1_W → WR1 → WR1_W → RD2 → RD2_W → WR2 → WR2_W (→ VERIFY) → RST_HOLD.
- RST_HOLD: pll_rst=1 for exactly RST_CYCLES cycles, then pll_rst=0 and go to WAIT_LOCK.
- WAIT_LOCK:
  - Synchronised lock high → IDLE, done pulse (also pulses after power-on lock).
  - LOCK_TIMEOUT cycles elapse without lock → increment retry count and go to RST_HOLD.
  - Timeout with retry count == MAX_RETRY → err pulse, err_code=10, go to IDLE with pll_rst=0.
- IDLE: cfg_ready=1. On transfer, latch cfg_sel/cfg_divide, clear err_code and retry count, set pll_rst=1, go to RD1. pll_rst stays high through all DRP states.
- Addresses: ClkReg1 = 0x08 (sel 0) / 0x0A (sel 1); ClkReg2 = 0x09 / 0x0B.
- Divide encoding, D = latched divide (0 → 128):
  - high = D>>1, low = D-high; each stored in 6 bits, so 64 encodes as 0.
  - edge = D[0]; no_count = (D==1).
- ClkReg1 write: keep rd[15:12], new [11:6]=high, [5:0]=low.
- ClkReg2 write: keep rd[15:8] except [7]=edge, [6]=no_count, keep rd[5:0].
- DRP access:
  - den is a one-cycle pulse; dwe=1 with den for writes only.
  - Read data is captured on the drdy cycle.
  - The next den issues no earlier than the cycle after drdy.
  - drdy not seen within DRDY_TIMEOUT cycles of den → err pulse, err_code=01, go to RST_HOLD (PLL re-locked with whatever was written).
- Lock loss in IDLE (synchronised lock falls while pll_rst=0) → go to RST_HOLD automatically with retry count cleared; cfg_ready drops the next cycle.
- Requests while busy are not accepted; cfg_valid may stay high and is accepted on return to IDLE.
- reset_n low mid-sequence aborts immediately to reset values; a partially written DRP register is not restored.
- done and err are never high in the same cycle.

Optional Feature:
Macro PLL_DRP_READBACK_EN.
- Defined: after each write, the VERIFY state re-reads the same address and compares against the written value. Mismatch → err pulse, err_code=11, go to RST_HOLD.
- Not defined: VERIFY state absent; err_code=11 is never produced. Latency is reduced by two DRP transactions.

Test Plan:
1. Power-on: release reset_n, model asserts LOCKED 100 cycles after pll_rst falls → pll_rst high exactly 16 cycles; done pulses once; locked=1; cfg_ready=1.
2. cfg_sel=0, cfg_divide=5, DRP model ClkReg1=0xF000, ClkReg2=0x0000 → writes 0x08←0xF083, 0x09←0x0080; pll_rst high throughout DRP phase; done on relock.
3. cfg_divide=0 (128) on CLKOUT1 → 0x0A[11:0]=0x000, 0x0B[7:6]=00; cfg_divide=1 → high=0, low=1, ClkReg2 bit 6=1, bit 7=1.
4. PLL model never locks → exactly 4 reset pulses (1+MAX_RETRY), then err pulse with err_code=10, busy=0.
5. DRP model withholds drdy → err pulse 256 cycles after den, err_code=01; then normal relock sequence follows.
6. Drop LOCKED in IDLE → pll_rst rises within 3 cycles (sync + FSM); cfg_valid held high during relock is accepted only after done.
